// File: rtl/uart_tx_frame.sv
// ----------------------------------------------------------------------------
// uart_tx_frame : parametrised UART transmitter with valid/ready character input
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_frame #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 pin,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] c_cnt_last  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    c_data_last = 4'(DATA_BITS - 1);
  localparam logic [3:0]    c_stop_last = 4'(STOP_BITS - 1);
  localparam logic          c_par_en    = (PARITY == 1) || (PARITY == 2);
  localparam logic          c_par_odd   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  pin_q, pin_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  w_accept;
  logic                  w_bit_end;

  assign w_accept  = tx_valid && ready_q;
  assign w_bit_end = (cnt_q == c_cnt_last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;

    // ready_q is only high in IDLE or the final stop clock, so loading here is safe
    if (w_accept) begin
      shift_d = tx_data;
      par_d   = (^tx_data) ^ c_par_odd;
    end

    unique case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == c_data_last) begin
            bit_d   = '0;
            state_d = c_par_en ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          cnt_d = '0;
          if (bit_q == c_stop_last) begin
            bit_d   = '0;
            state_d = w_accept ? S_START : S_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so the line moves on the accepting edge
    unique case (state_d)
      S_START:  pin_d = 1'b0;
      S_DATA:   pin_d = shift_d[0];
      S_PARITY: pin_d = par_d;
      default:  pin_d = 1'b1;
    endcase
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (bit_d == c_stop_last) && (cnt_d == c_cnt_last);
    ready_d = (state_d == S_IDLE) || done_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pin_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pin_q   <= pin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign pin      = pin_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_ready = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_frame : scoreboard bench over four parameter sets of uart_tx_frame
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_frame;

  localparam int N = 4;
  // instance 0: 8N1/4, 1: 8E2/4, 2: 8O2/4, 3: 5N1/1
  localparam int DB[N]  = '{8, 8, 8, 5};
  localparam int CPB[N] = '{4, 4, 4, 1};
  localparam int PAR[N] = '{0, 1, 2, 0};
  localparam int SB[N]  = '{1, 2, 2, 1};

  // per-clock expectation packed as {pin, done, tx_ready, busy}
  typedef logic [3:0] ent_t;

  ent_t       sb_q[N][$];
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] data[N];
  logic       valid[N];
  logic       pin_s[N];
  logic       rdy_s[N];
  logic       busy_s[N];
  logic       done_s[N];
  int         acc_cnt[N] = '{default: 0};
  int         done_cnt[N] = '{default: 0};
  logic       rst_at_edge = 1'b0;
  logic       started = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .tx_data(data[0][7:0]), .tx_valid(valid[0]),
    .tx_ready(rdy_s[0]), .pin(pin_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u_8e2 (
    .clk(clk), .reset(reset), .tx_data(data[1][7:0]), .tx_valid(valid[1]),
    .tx_ready(rdy_s[1]), .pin(pin_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u_8o2 (
    .clk(clk), .reset(reset), .tx_data(data[2][7:0]), .tx_valid(valid[2]),
    .tx_ready(rdy_s[2]), .pin(pin_s[2]), .busy(busy_s[2]), .done(done_s[2]));

  uart_tx_frame #(.DATA_BITS(5), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1)) u_5n1 (
    .clk(clk), .reset(reset), .tx_data(data[3][4:0]), .tx_valid(valid[3]),
    .tx_ready(rdy_s[3]), .pin(pin_s[3]), .busy(busy_s[3]), .done(done_s[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Expected line for one accepted character, one entry per clock
  task automatic push_frame(input int k, input logic [8:0] d);
    logic bitv[13];
    logic p;
    int   nb;
    int   idx;
    p   = 1'b0;
    idx = 0;
    bitv[idx++] = 1'b0;
    for (int i = 0; i < DB[k]; i++) begin
      bitv[idx++] = d[i];
      p = p ^ d[i];
    end
    if (PAR[k] == 1) bitv[idx++] = p;
    if (PAR[k] == 2) bitv[idx++] = ~p;
    for (int i = 0; i < SB[k]; i++) bitv[idx++] = 1'b1;
    nb = idx;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < CPB[k]; c++) begin
        logic last;
        last = (b == nb - 1) && (c == CPB[k] - 1);
        sb_q[k].push_back({bitv[b], last, last, 1'b1});
      end
    end
  endtask

  // Acceptance observer: push the expected frame on each handshake edge
  always @(posedge clk) begin
    started     <= 1'b1;
    rst_at_edge <= !reset;
    for (int k = 0; k < N; k++) begin
      if (!reset) begin
        sb_q[k].delete();
      end else if (valid[k] && rdy_s[k]) begin
        push_frame(k, data[k]);
        acc_cnt[k] <= acc_cnt[k] + 1;
      end
    end
  end

  // Output monitor: every clock of every instance is compared
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < N; k++) begin
        ent_t e_exp;
        if (rst_at_edge)              e_exp = 4'b1000;
        else if (sb_q[k].size() > 0)  e_exp = sb_q[k].pop_front();
        else                          e_exp = 4'b1010;
        check($sformatf("u%0d pin/done/rdy/busy", k),
              32'({pin_s[k], done_s[k], rdy_s[k], busy_s[k]}), 32'(e_exp));
        if (done_s[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
      end
    end
  end

  task automatic send(input int k, input logic [8:0] d, input bit keep);
    int n0;
    n0       = acc_cnt[k];
    valid[k] = 1'b1;
    data[k]  = d;
    for (int t = 0; t < 400 && acc_cnt[k] == n0; t++) @(negedge clk);
    check($sformatf("u%0d accept", k), acc_cnt[k] - n0, 1);
    if (!keep) begin
      valid[k] = 1'b0;
      data[k]  = ~d;
    end
  endtask

  task automatic wait_idle(input int k);
    for (int t = 0; t < 600 && sb_q[k].size() != 0; t++) @(negedge clk);
    check($sformatf("u%0d drain", k), sb_q[k].size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int c0;
    int a0;
    for (int k = 0; k < N; k++) begin
      valid[k] = 1'b0;
      data[k]  = '0;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    send(0, 9'h0A5, 1'b0); wait_idle(0);
    send(1, 9'h0A5, 1'b0); wait_idle(1);
    send(2, 9'h0A5, 1'b0); wait_idle(2);

    c0 = done_cnt[0];
    send(0, 9'h000, 1'b1);
    send(0, 9'h0FF, 1'b0);
    wait_idle(0);
    check("b2b done pulses", done_cnt[0] - c0, 2);

    send(3, 9'h015, 1'b0); wait_idle(3);
    c0 = done_cnt[3];
    send(3, 9'h00A, 1'b1);
    send(3, 9'h01F, 1'b0);
    wait_idle(3);
    check("b2b cpb1 done pulses", done_cnt[3] - c0, 2);

    // valid raised and dropped while the block is busy must not be taken
    a0 = acc_cnt[0];
    send(0, 9'h081, 1'b0);
    repeat (5) @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 9'h07E;
    repeat (5) @(negedge clk);
    valid[0] = 1'b0;
    wait_idle(0);
    check("dropped valid accepts", acc_cnt[0] - a0, 1);

    c0 = done_cnt[0];
    send(0, 9'h05A, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset abort done pulses", done_cnt[0] - c0, 0);
    send(0, 9'h0C3, 1'b0); wait_idle(0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
